// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response bundle.
// The core drives the master side; the memory responder sits on the slave side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_mode;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_mode, req_signed, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_mode, req_signed, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with word/half/byte access and lane-level writes.
// One request in flight at a time; each request produces exactly one resp_valid pulse.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {
    MODE_WORD = 2'b00,
    MODE_HALF = 2'b01,
    MODE_BYTE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  mode_e       lat_mode;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        go_resp;
  logic        mem_we;
  logic        cur_write;
  logic        cur_signed;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  mode_e       cur_mode;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign go_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

  // With LATENCY==1 the commit edge is the accept edge, so the live bus is the request.
  always_comb begin
    if (state == IDLE) begin
      cur_write  = bus.req_write;
      cur_signed = bus.req_signed;
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
      cur_mode   = mode_e'(bus.req_mode);
    end else begin
      cur_write  = lat_write;
      cur_signed = lat_signed;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      cur_mode   = lat_mode;
    end
  end

  assign word_idx = cur_addr[ADDR_WIDTH+1:2];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign rd_half  = rd_word[{cur_addr[1], 4'b0000} +: 16];

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    err     = (cur_addr[31:ADDR_WIDTH+2] != '0);
    be      = 4'b0000;
    wr_word = cur_wdata;
    ld_data = rd_word;
    case (cur_mode)
      MODE_WORD: begin
        err |= (cur_addr[1:0] != 2'b00);
        be   = 4'b1111;
      end
      MODE_HALF: begin
        err    |= cur_addr[0];
        be      = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{cur_wdata[15:0]}};
        ld_data = {{16{cur_signed & rd_half[15]}}, rd_half};
      end
      MODE_BYTE: begin
        be      = 4'b0001 << cur_addr[1:0];
        wr_word = {4{cur_wdata[7:0]}};
        ld_data = {{24{cur_signed & rd_byte[7]}}, rd_byte};
      end
      default: err = 1'b1;
    endcase
  end

  // Gated with reset so a request seen while reset is held can never reach the array.
  assign mem_we = go_resp && cur_write && !err && reset;

  // NOTE: the array is deliberately not reset; its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lat_write      <= 1'b0;
      lat_signed     <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_mode       <= MODE_WORD;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write     <= bus.req_write;
            lat_signed    <= bus.req_signed;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            lat_mode      <= mode_e'(bus.req_mode);
            cnt           <= CNT_INIT;
            bus.req_ready <= 1'b0;
            state         <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
      if (go_resp) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= err;
        bus.resp_rdata <= (err || cur_write) ? 32'h0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for access/error/reset cases,
// LATENCY=1 instance for the back-to-back handshake cadence.
module tb_dmem_responder;

  localparam logic [1:0] M_WORD = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_BYTE = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on bus_a; returns the response and the cycle (1-based) in which resp_valid was seen.
  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [1:0] mode,
                       input logic sgn, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    bus_a.req_valid  = 1'b1;
    bus_a.req_write  = wr;
    bus_a.req_addr   = addr;
    bus_a.req_mode   = mode;
    bus_a.req_signed = sgn;
    bus_a.req_wdata  = wdata;
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    bus_a.req_wdata = 32'h5A5A_5A5A;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus_a.resp_valid) begin
        lat   = n;
        rdata = bus_a.resp_rdata;
        err   = bus_a.resp_err;
        break;
      end
    end
    if (lat == 0) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("resp_pulse_width", {31'd0, bus_a.resp_valid}, 32'd0);
      check("ready_after_resp", {31'd0, bus_a.req_ready}, 32'd1);
    end
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] mode,
                          input logic sgn, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    req_a(1'b0, addr, mode, sgn, 32'h0, rd, e, lat);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_latency"}, lat, 32'd2);
  endtask

  task automatic store_chk(input string tag, input logic [31:0] addr, input logic [1:0] mode,
                           input logic [31:0] wdata, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    req_a(1'b1, addr, mode, 1'b0, wdata, rd, e, lat);
    check({tag, "_data"}, rd, 32'h0);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_latency"}, lat, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0;
    bus_a.req_mode  = M_WORD; bus_a.req_signed = 1'b0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0;
    bus_b.req_mode  = M_WORD; bus_b.req_signed = 1'b0; bus_b.req_wdata = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    check("rst_rdata", bus_a.resp_rdata, 32'h0);
    check("rst_err", {31'd0, bus_a.resp_err}, 32'd0);
    reset = 1'b1;

    // Reset in the middle of a store's WAIT cycle drops it before commit.
    store_chk("t1_pre", 32'h10, M_WORD, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_addr = 32'h10;
    bus_a.req_mode  = M_WORD; bus_a.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    check("t1_ready_in_wait", {31'd0, bus_a.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("t1_rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("t1_rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    check("t1_rst_rdata", bus_a.resp_rdata, 32'h0);
    check("t1_rst_err", {31'd0, bus_a.resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_no_resp_after_rst", {31'd0, bus_a.resp_valid}, 32'd0);
    reset = 1'b1;
    load_chk("t1_load", 32'h10, M_WORD, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Word store and readback.
    store_chk("t2_store", 32'h20, M_WORD, 32'h1122_3344, 1'b0);
    load_chk("t2_load", 32'h20, M_WORD, 1'b0, 32'h1122_3344, 1'b0);

    // Byte lane 1 write, sign/zero extension.
    store_chk("t3_store", 32'h21, M_BYTE, 32'hFFFF_FF80, 1'b0);
    load_chk("t3_ld_sb", 32'h21, M_BYTE, 1'b1, 32'hFFFF_FF80, 1'b0);
    load_chk("t3_ld_ub", 32'h21, M_BYTE, 1'b0, 32'h0000_0080, 1'b0);
    load_chk("t3_word", 32'h20, M_WORD, 1'b0, 32'h1122_8044, 1'b0);
    load_chk("t3_ld_sb0", 32'h20, M_BYTE, 1'b1, 32'h0000_0044, 1'b0);

    // Upper half write, half loads, byte from the written half.
    store_chk("t4_store", 32'h22, M_HALF, 32'h0000_BEEF, 1'b0);
    load_chk("t4_ld_sh", 32'h22, M_HALF, 1'b1, 32'hFFFF_BEEF, 1'b0);
    load_chk("t4_ld_uh", 32'h22, M_HALF, 1'b0, 32'h0000_BEEF, 1'b0);
    load_chk("t4_word", 32'h20, M_WORD, 1'b0, 32'hBEEF_8044, 1'b0);
    load_chk("t4_ld_ub3", 32'h23, M_BYTE, 1'b0, 32'h0000_00BE, 1'b0);
    load_chk("t4_ld_sh0", 32'h20, M_HALF, 1'b1, 32'hFFFF_8044, 1'b0);

    // Error cases; erroring stores must leave the array untouched.
    load_chk("t5_word_mis", 32'h21, M_WORD, 1'b0, 32'h0, 1'b1);
    load_chk("t5_half_mis", 32'h23, M_HALF, 1'b0, 32'h0, 1'b1);
    load_chk("t5_rsvd", 32'h20, M_RSVD, 1'b0, 32'h0, 1'b1);
    load_chk("t5_range", 32'h0000_1000, M_WORD, 1'b0, 32'h0, 1'b1);
    store_chk("t5_st_range", 32'h0000_1020, M_WORD, 32'hFFFF_FFFF, 1'b1);
    store_chk("t5_st_mis", 32'h21, M_HALF, 32'h0000_1234, 1'b1);
    store_chk("t5_st_rsvd", 32'h20, M_RSVD, 32'h0000_0000, 1'b1);
    load_chk("t5_unchanged", 32'h20, M_WORD, 1'b0, 32'hBEEF_8044, 1'b0);

    // LATENCY=1 with req_valid held: accept every other cycle.
    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_write = 1'b1; bus_b.req_addr = 32'h4;
    bus_b.req_mode  = M_WORD; bus_b.req_wdata = 32'h1234_5678;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t6_ready_c%0d", k), {31'd0, bus_b.req_ready}, {31'd0, (k % 2) == 0});
      check($sformatf("t6_resp_c%0d", k), {31'd0, bus_b.resp_valid}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 1) check($sformatf("t6_err_c%0d", k), {31'd0, bus_b.resp_err}, 32'd0);
      @(negedge clk);
    end
    bus_b.req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
